// File: rtl/maxterm_evaluator_pkg.sv
// Shared types and limits for the maxterm evaluator (FSM states, size bounds).
// Optional comparison feature in the top is enabled by MAXTERM_EVALUATOR_CMP_EN.
package maxterm_evaluator_pkg;

  localparam int N_IN_MAX  = 6;
  localparam int N_OUT_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Output-select width: at least one bit even for a single function.
  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/maxterm_evaluator_if.sv
// Handshake bundle for the maxterm evaluator: table writes, evaluation
// requests, results and sweep control. The DUT uses the slave modport.
interface maxterm_evaluator_if
  import maxterm_evaluator_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int SW    = sel_width(N_OUT)
);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [SW-1:0]        cfg_sel;
  logic [2**N_IN-1:0]   cfg_table;

  logic                 in_valid;
  logic                 in_ready;
  logic [N_IN-1:0]      in_vec;

  logic                 out_valid;
  logic                 out_ready;
  logic [N_IN-1:0]      out_vec;
  logic [N_OUT-1:0]     out_res;

  logic                 start;
  logic                 busy;
  logic                 done;

  modport slave (
    input  cfg_valid, cfg_sel, cfg_table, in_valid, in_vec, out_ready, start,
    output cfg_ready, in_ready, out_valid, out_vec, out_res, busy, done
  );

  modport master (
    output cfg_valid, cfg_sel, cfg_table, in_valid, in_vec, out_ready, start,
    input  cfg_ready, in_ready, out_valid, out_vec, out_res, busy, done
  );

endinterface

// File: rtl/maxterm_evaluator_table.sv
// Truth-table storage (module maxterm_table): one registered table per output
// function, a single write port and a combinational lookup by input vector.
module maxterm_table
  import maxterm_evaluator_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int SW    = sel_width(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [SW-1:0]      wr_sel,
  input  logic [2**N_IN-1:0] wr_data,
  input  logic [N_IN-1:0]    rd_vec,
  output logic [N_OUT-1:0]   rd_res
);

  localparam int DEPTH = 2**N_IN;

  logic [N_OUT-1:0][DEPTH-1:0] tbl_q, tbl_d;

  // Selects that do not name an existing function match no row and are dropped.
  always_comb begin
    tbl_d = tbl_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr_en && (int'(wr_sel) == k)) begin
        tbl_d[k] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '1;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    rd_res = '0;
    for (int k = 0; k < N_OUT; k++) begin
      rd_res[k] = tbl_q[k][rd_vec];
    end
  end

endmodule

// File: rtl/maxterm_evaluator.sv
// Evaluates N_OUT boolean functions given as maxterm truth tables, either per
// request or as an exhaustive sweep. MAXTERM_EVALUATOR_CMP_EN adds mism/mism_cnt.
module maxterm_evaluator
  import maxterm_evaluator_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int SW    = sel_width(N_OUT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  maxterm_evaluator_if.slave   bus
`ifdef MAXTERM_EVALUATOR_CMP_EN
  ,
  output logic [N_IN:0]        mism_cnt,
  output logic                 mism
`endif
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [N_IN-1:0]   out_vec_q, out_vec_d;
  logic [N_OUT-1:0]  out_res_q, out_res_d;

  logic              can_load;
  logic              cfg_fire;
  logic              in_fire;
  logic              sweep_load;
  logic [N_IN-1:0]   rd_vec;
  logic [N_OUT-1:0]  rd_res;

  assign can_load      = !out_valid_q || bus.out_ready;
  assign bus.cfg_ready = (state_q == ST_IDLE);
  // A start request wins over a simultaneous evaluation request.
  assign bus.in_ready  = (state_q == ST_IDLE) && can_load && !bus.start;
  assign cfg_fire      = bus.cfg_valid && bus.cfg_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign sweep_load    = (state_q == ST_SWEEP) && can_load;
  assign rd_vec        = (state_q == ST_SWEEP) ? cnt_q : bus.in_vec;

  maxterm_table #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .SW    (SW)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_fire),
    .wr_sel  (bus.cfg_sel),
    .wr_data (bus.cfg_table),
    .rd_vec  (rd_vec),
    .rd_res  (rd_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (sweep_load) begin
          if (cnt_q == LAST_VEC) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result register: loads from a request or the sweep counter, else drains.
  always_comb begin
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_res_d   = out_res_q;
    if (in_fire || sweep_load) begin
      out_valid_d = 1'b1;
      out_vec_d   = rd_vec;
      out_res_d   = rd_res;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_res_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_res_q   <= out_res_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_res   = out_res_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

`ifdef MAXTERM_EVALUATOR_CMP_EN
  logic              out_sweep_q, out_sweep_d;
  logic [N_IN:0]     mism_cnt_q, mism_cnt_d;

  assign mism = out_valid_q && (out_res_q[0] != out_res_q[1]);

  // Only sweep results count, including the last one drained after DONE.
  always_comb begin
    out_sweep_d = out_sweep_q;
    mism_cnt_d  = mism_cnt_q;
    if (in_fire || sweep_load) begin
      out_sweep_d = sweep_load;
    end
    if ((state_q == ST_IDLE) && bus.start) begin
      mism_cnt_d = '0;
    end else if (out_valid_q && bus.out_ready && out_sweep_q && mism) begin
      mism_cnt_d = mism_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sweep_q <= 1'b0;
      mism_cnt_q  <= '0;
    end else begin
      out_sweep_q <= out_sweep_d;
      mism_cnt_q  <= mism_cnt_d;
    end
  end

  assign mism_cnt = mism_cnt_q;
`endif

endmodule

// File: doc/maxterm_evaluator.md
MAXTERM_EVALUATOR -- requirements
Module: maxterm_evaluator

Interface
REQ-001 Parameter: N_IN, default 4, number of boolean inputs (2..6).
REQ-002 Parameter: N_OUT, default 2, number of independent output functions (1..4).
REQ-003 Parameter: SW = max(1, clog2(N_OUT)), output-select width.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port: cfg_valid / cfg_ready  in / out  1 / 1  table-write handshake.
REQ-007 Port: cfg_sel  in  SW  index of the output function being written.
REQ-008 Port: cfg_table  in  2**N_IN  truth table; bit i = 0 marks maxterm i (function = 0 at input vector i).
REQ-009 Port: in_valid / in_ready  in / out  1 / 1  evaluation-request handshake.
REQ-010 Port: in_vec  in  N_IN  input vector; bit N_IN-1 is MSB (X in the 4-input case).
REQ-011 Port: out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-012 Port: out_vec  out  N_IN  vector that produced the result.
REQ-013 Port: out_res  out  N_OUT  bit k = table k indexed by out_vec.
REQ-014 Port: start  in  1  single-cycle request for an exhaustive sweep.
REQ-015 Port: busy / done  out / out  1 / 1  sweep active / single-cycle sweep-complete pulse.

Function
REQ-016 Tables SHALL be held in registers, N_OUT x 2**N_IN bits.
REQ-017 cfg_ready SHALL be 1 only in IDLE; a write SHALL take effect on the cycle after the handshake; a cfg_sel >= N_OUT SHALL be accepted and discarded.
REQ-018 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready).
REQ-019 An accepted request SHALL appear on out_* exactly one cycle later (registered, latency 1); a full-throughput stream SHALL sustain one result per cycle.
REQ-020 out_valid, out_vec and out_res SHALL hold stable while out_valid && !out_ready.
REQ-021 Simultaneous cfg and in handshakes SHALL evaluate in_vec against the old table.
REQ-022 FSM states: IDLE, SWEEP, DONE; IDLE->SWEEP on start; SWEEP->DONE after vector 2**N_IN-1 is loaded into the output register; DONE->IDLE unconditionally after one cycle.
REQ-023 In SWEEP an internal N_IN-bit counter starting at 0 SHALL supply the vectors, advancing only when the output register can load (!out_valid || out_ready); backpressure SHALL stall it without skipping or repeating vectors.
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 in SWEEP and DONE.
REQ-025 start while busy SHALL be ignored; start coincident with in_valid in IDLE SHALL take priority, with the request not accepted (in_ready forced 0 that cycle).
REQ-026 The counter SHALL NOT wrap within a sweep; it SHALL be cleared to 0 on entry to SWEEP.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, counter 0, every table all-ones (constant-1 functions), out_valid 0, out_vec 0, out_res 0, done 0, busy 0.
REQ-028 Reset mid-sweep SHALL abandon the sweep with no done pulse; any pending result SHALL be lost.

Configuration
REQ-029 Macro MAXTERM_EVALUATOR_CMP_EN SHALL, when defined, add ports mism_cnt (out, N_IN+1) and mism (out, 1).
REQ-030 With the macro, mism SHALL equal out_res[0] != out_res[1] while out_valid, else 0; mism_cnt SHALL clear on SWEEP entry and increment once per handshaken sweep result with mism = 1, holding its value after DONE; the macro requires N_OUT >= 2.
REQ-031 Without the macro, neither port nor any comparison logic SHALL exist.

Structure
REQ-032 A shared package SHALL hold the FSM state enum and the limits N_IN_MAX = 6 and N_OUT_MAX = 4.
REQ-033 Table storage plus lookup SHALL be one sub-module, maxterm_table (write port plus combinational read by vector).

Verification
REQ-034 Reset, then in_vec = 4'b1010 -> out_res = 2'b11 one cycle later.
REQ-035 Write table0 = 16'hCCEF, in_vec = 4'b1000 -> out_res[0] = 0; in_vec = 4'b0111 -> out_res[0] = 1.
REQ-036 Tables 0 and 1 both 16'hCCEF, start, out_ready = 1 -> 16 results, vectors 0..15 in order, done on the cycle after vector 15; with the macro, mism_cnt = 0.
REQ-037 Table1 = 16'hCCEE, sweep -> mism_cnt = 1, mism high only at out_vec = 0.
REQ-038 Sweep with out_ready toggled every other cycle -> same 16 vectors with no gaps or repeats; start issued mid-sweep is ignored.
REQ-039 rst_n pulsed low at vector 7 -> outputs cleared immediately, no done pulse, tables back to all-ones.
